// File: rtl/rv_pkg.sv
// Shared register-file types: data/address widths and the write-request record.
package rv_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef struct packed {
        logic [REG_AW-1:0] adr;
        logic [XLEN-1:0]   data;
    } reg_wr_t;

endpackage

// File: rtl/regfile_writeback_if.sv
// Producer handshakes, flush, register-file write port and status for regfile_writeback.
interface regfile_writeback_if;
    import rv_pkg::*;

    logic              alu_valid;
    logic              alu_ready;
    logic [REG_AW-1:0] alu_adr;
    logic [XLEN-1:0]   alu_data;
    logic              ld_valid;
    logic              ld_ready;
    logic [REG_AW-1:0] ld_adr;
    logic [XLEN-1:0]   ld_data;
    logic              flush;
    logic              wend;
    logic [REG_AW-1:0] write_adr;
    logic [XLEN-1:0]   write_data;
    logic [31:0]       pend_mask;
    logic              busy;

    modport master (
        output alu_valid, alu_adr, alu_data, ld_valid, ld_adr, ld_data, flush,
        input  alu_ready, ld_ready, wend, write_adr, write_data, pend_mask, busy
    );

    modport slave (
        input  alu_valid, alu_adr, alu_data, ld_valid, ld_adr, ld_data, flush,
        output alu_ready, ld_ready, wend, write_adr, write_data, pend_mask, busy
    );

endinterface

// File: rtl/wb_fifo.sv
// In-order synchronous FIFO of write requests with a per-entry valid/adr view.
module wb_fifo
    import rv_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = reg_wr_t,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  T                  wdata,
    input  logic              pop,
    input  logic              clear,
    output T                  head,
    output logic              full,
    output logic              empty,
    output logic [CW-1:0]     count,
    output logic [DEPTH-1:0]  ent_valid,
    output logic [REG_AW-1:0] ent_adr [DEPTH]
);

    T              mem_q [DEPTH];
    T              mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full    = (cnt_q == CW'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Entry i is live when its distance from the read pointer is below the count.
    always_comb begin
        logic [PW-1:0] off;
        ent_valid = '0;
        off       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off          = PW'(i) - rd_ptr_q;
            ent_valid[i] = (CW'(off) < cnt_q);
            ent_adr[i]   = mem_q[i].adr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write front end: load-priority arbitration, in-order queue, registered write port.
module regfile_writeback
    import rv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    regfile_writeback_if.slave  bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    reg_wr_t           head;
    reg_wr_t           push_data;
    logic              full, empty, push, pop;
    logic [CW-1:0]     count;
    logic [DEPTH-1:0]  ent_valid;
    logic [REG_AW-1:0] ent_adr [DEPTH];

    logic              wend_q, wend_d;
    logic [REG_AW-1:0] write_adr_q, write_adr_d;
    logic [XLEN-1:0]   write_data_q, write_data_d;
    logic [31:0]       pend_mask;

    // Readiness looks only at the registered full flag, never at this cycle's pop.
    assign bus.ld_ready  = !full;
    assign bus.alu_ready = !full && !bus.ld_valid;

    always_comb begin
        push_data = '0;
        push      = 1'b0;
        if (bus.ld_valid) begin
            push_data.adr  = bus.ld_adr;
            push_data.data = bus.ld_data;
            push           = !full;
        end else if (bus.alu_valid) begin
            push_data.adr  = bus.alu_adr;
            push_data.data = bus.alu_data;
            push           = !full;
        end
    end

    assign pop = !empty;

    wb_fifo #(.DEPTH(DEPTH), .T(reg_wr_t)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .wdata     (push_data),
        .pop       (pop),
        .clear     (bus.flush),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .ent_valid (ent_valid),
        .ent_adr   (ent_adr)
    );

    // x0 entries still drain but never raise the write enable.
    always_comb begin
        wend_d       = 1'b0;
        write_adr_d  = write_adr_q;
        write_data_d = write_data_q;
        if (pop) begin
            wend_d       = (head.adr != '0);
            write_adr_d  = head.adr;
            write_data_d = head.data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wend_q       <= 1'b0;
            write_adr_q  <= '0;
            write_data_q <= '0;
        end else begin
            wend_q       <= wend_d;
            write_adr_q  <= write_adr_d;
            write_data_q <= write_data_d;
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_valid[i]) begin
                pend_mask[ent_adr[i]] = 1'b1;
            end
        end
        if (wend_q) begin
            pend_mask[write_adr_q] = 1'b1;
        end
        pend_mask[0] = 1'b0;
    end

    assign bus.wend       = wend_q;
    assign bus.write_adr  = write_adr_q;
    assign bus.write_data = write_data_q;
    assign bus.pend_mask  = pend_mask;
    assign bus.busy       = (count != '0) || wend_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed and random stimulus for regfile_writeback against a queue-based reference model.
module tb_regfile_writeback;
    import rv_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_writeback_if bus ();

    regfile_writeback #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks = 0;
    int          errors = 0;
    reg_wr_t     mq [$];
    logic        m_wend;
    logic [4:0]  m_adr;
    logic [31:0] m_data;
    logic [31:0] shadow_rf [32];
    logic [31:0] wr_log [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_pend();
        logic [31:0] m;
        m = '0;
        foreach (mq[i]) m[mq[i].adr] = 1'b1;
        if (m_wend) m[m_adr] = 1'b1;
        m[0] = 1'b0;
        return m;
    endfunction

    task automatic drive(input logic lv, input logic [4:0] la, input logic [31:0] ldd,
                         input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic fl);
        bus.ld_valid  = lv;
        bus.ld_adr    = la;
        bus.ld_data   = ldd;
        bus.alu_valid = av;
        bus.alu_adr   = aa;
        bus.alu_data  = ad;
        bus.flush     = fl;
    endtask

    // One clock: check readies, advance the model on the edge, then check outputs.
    task automatic cycle();
        logic    pre_full, r, lv, av, fl;
        reg_wr_t ldr, alr, h;
        pre_full = (mq.size() == DEPTH);
        #1;
        chk("ld_ready", bus.ld_ready, !pre_full);
        chk("alu_ready", bus.alu_ready, !pre_full && !bus.ld_valid);
        r   = rst;
        lv  = bus.ld_valid;
        av  = bus.alu_valid;
        fl  = bus.flush;
        ldr = reg_wr_t'{adr: bus.ld_adr, data: bus.ld_data};
        alr = reg_wr_t'{adr: bus.alu_adr, data: bus.alu_data};
        @(posedge clk);
        if (r) begin
            mq.delete();
            m_wend = 1'b0;
            m_adr  = '0;
            m_data = '0;
        end else begin
            if (mq.size() != 0) begin
                h      = mq.pop_front();
                m_wend = (h.adr != 0);
                m_adr  = h.adr;
                m_data = h.data;
            end else begin
                m_wend = 1'b0;
            end
            if (fl) mq.delete();
            else if (lv && !pre_full) mq.push_back(ldr);
            else if (av && !pre_full) mq.push_back(alr);
        end
        #1;
        chk("wend", bus.wend, m_wend);
        chk("write_adr", bus.write_adr, m_adr);
        chk("write_data", bus.write_data, m_data);
        chk("pend_mask", bus.pend_mask, model_pend());
        chk("busy", bus.busy, (mq.size() != 0) || m_wend);
        if (bus.wend) begin
            shadow_rf[bus.write_adr] = bus.write_data;
            wr_log.push_back(bus.write_data);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            drive(0, 0, 0, 0, 0, 0, 0);
            cycle();
        end
    endtask

    initial begin
        int start;
        logic [31:0] got;
        foreach (shadow_rf[i]) shadow_rf[i] = '0;
        m_wend = 1'b0;
        m_adr  = '0;
        m_data = '0;

        // Power-up reset without checks, then a checked reset cycle with ld_valid high.
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        drive(1, 5'd7, 32'h77, 1, 5'd8, 32'h88, 0);
        cycle();
        rst = 1'b0;
        idle(1);

        // Single ALU request.
        drive(0, 0, 0, 1, 5'd5, 32'hDEADBEEF, 0);
        cycle();
        idle(4);
        chk("single_r5", shadow_rf[5], 32'hDEADBEEF);

        // Both producers at once; load wins, ALU follows.
        drive(1, 5'd3, 32'h11, 1, 5'd3, 32'h22, 0);
        cycle();
        drive(0, 0, 0, 1, 5'd3, 32'h22, 0);
        cycle();
        idle(4);
        chk("simul_r3", shadow_rf[3], 32'h22);
        got = (wr_log.size() >= 2) ? wr_log[wr_log.size()-2] : 32'hFFFF_FFFF;
        chk("simul_first", got, 32'h11);

        // x0 destination drains silently.
        start = wr_log.size();
        drive(0, 0, 0, 1, 5'd0, 32'h1234, 0);
        cycle();
        idle(4);
        chk("x0_nowrite", wr_log.size() - start, 0);

        // Stream 12 loads back to back across pointer wraps.
        start = wr_log.size();
        for (int k = 1; k <= 12; k++) begin
            drive(1, 5'($urandom_range(1, 31)), 32'(k), 0, 0, 0, 0);
            cycle();
        end
        idle(4);
        chk("stream_cnt", wr_log.size() - start, 12);
        for (int k = 0; k < 12; k++) begin
            got = (start + k < wr_log.size()) ? wr_log[start+k] : 32'hFFFF_FFFF;
            chk("stream_ord", got, 32'(k + 1));
        end

        // Flush while r1 pops: r1 lands, r2/r3 never do.
        shadow_rf[1] = '0;
        shadow_rf[2] = '0;
        shadow_rf[3] = '0;
        drive(1, 5'd1, 32'hA1, 0, 0, 0, 0);
        cycle();
        drive(1, 5'd2, 32'hA2, 1, 5'd3, 32'hA3, 1);
        cycle();
        idle(4);
        chk("flush_r1", shadow_rf[1], 32'hA1);
        chk("flush_r2", shadow_rf[2], 32'h0);
        chk("flush_r3", shadow_rf[3], 32'h0);

        // Reset in the middle of a stream.
        for (int k = 0; k < 3; k++) begin
            drive(1, 5'(10 + k), 32'(32'h100 + k), 0, 0, 0, 0);
            cycle();
        end
        rst = 1'b1;
        drive(1, 5'd20, 32'h200, 0, 0, 0, 0);
        cycle();
        rst = 1'b0;
        idle(3);

        // Random traffic with occasional flush and reset.
        for (int k = 0; k < 400; k++) begin
            rst = ($urandom_range(0, 63) == 0);
            drive($urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom,
                  $urandom_range(0, 1) == 1, 5'($urandom_range(0, 31)), $urandom,
                  $urandom_range(0, 15) == 0);
            cycle();
        end
        rst = 1'b0;
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
